// File: rtl/fpu_ss_pkg.sv
// Shared definitions for the FP subsystem dependency tracker.
//   fwd_sel_t : one-hot writeback-port forward select for one operand
//   cnt_width : width of a pending-write counter able to hold 0..max_inflight
//   WB_FPU / WB_LSU : writeback port indices (port 0 = FPU, port 1 = LSU)
package fpu_ss_pkg;

    localparam int unsigned WB_FPU       = 0;
    localparam int unsigned WB_LSU       = 1;
    localparam int unsigned NUM_WB_PORTS = 2;

    typedef logic [NUM_WB_PORTS-1:0] fwd_sel_t;

    function automatic int unsigned cnt_width(input int unsigned max_inflight);
        return $clog2(max_inflight + 1);
    endfunction

endpackage

// File: rtl/fpu_ss_id_scoreboard.sv
// Offload-ID commit scoreboard: one bit per possible offload ID.
// A bit is set when that ID commits (not killed) and cleared when a
// writeback for that ID retires. A set and a clear of the same ID in the
// same cycle leaves the bit set.
// Ports:
//   clk_i, rst_ni     clock, asynchronous active-low reset
//   flush_i           synchronous clear of every bit
//   set_i, set_id_i   commit strobe and committed ID
//   clr_valid_i       per-writeback-port retire strobe
//   clr_id_i          per-writeback-port retired ID
//   query_id_i        ID to look up
//   query_o           registered state of bit query_id_i
module fpu_ss_id_scoreboard #(
    parameter int unsigned ID_WIDTH = 4,
    parameter int unsigned NUM_WB   = 2
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             flush_i,
    input  logic                             set_i,
    input  logic [ID_WIDTH-1:0]              set_id_i,
    input  logic [NUM_WB-1:0]                clr_valid_i,
    input  logic [NUM_WB-1:0][ID_WIDTH-1:0]  clr_id_i,
    input  logic [ID_WIDTH-1:0]              query_id_i,
    output logic                             query_o
);

    localparam int unsigned DEPTH = 2 ** ID_WIDTH;

    logic [DEPTH-1:0] idsb_q;
    logic [DEPTH-1:0] idsb_d;

    // Clears are applied before the set so that a same-cycle set wins.
    always_comb begin
        idsb_d = idsb_q;
        for (int p = 0; p < NUM_WB; p++) begin
            if (clr_valid_i[p]) begin
                idsb_d[clr_id_i[p]] = 1'b0;
            end
        end
        if (set_i) begin
            idsb_d[set_id_i] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idsb_q <= '0;
        end else if (flush_i) begin
            idsb_q <= '0;
        end else begin
            idsb_q <= idsb_d;
        end
    end

    assign query_o = idsb_q[query_id_i];

endmodule

// File: rtl/fpu_ss_dep_tracker.sv
// FP register dependency tracker for the FPU subsystem.
// Counts outstanding FP-register writes per register and in total, flags
// RAW and saturation hazards for the issue candidate, selects same-cycle
// writeback forwarding, and tracks which offload IDs have committed.
// Optional feature macro: FPU_SS_DEP_FORWARDING_EN enables writeback
// forwarding on fwd_o; without it fwd_o is 0 and RAW hazards ignore
// same-cycle writebacks.
// Ports:
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   flush_i             synchronous clear of all tracking state
//   issue_*             candidate instruction (sources, dest, ID) and ready
//   commit_*            commit strobe / ID / kill
//   wb_*                per-port writeback strobe, register and ID
//   dep_o               candidate has a RAW or saturation hazard
//   fwd_o               per-operand one-hot writeback-port forward select
//   committed_o         candidate ID is committed
//   busy_o              any write outstanding (registered)
//   err_o               sticky writeback-underflow error
module fpu_ss_dep_tracker
    import fpu_ss_pkg::*;
#(
    parameter int unsigned NUM_FPR      = 32,
    parameter int unsigned NUM_WB       = 2,
    parameter int unsigned ID_WIDTH     = 4,
    parameter int unsigned MAX_INFLIGHT = 4
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            flush_i,
    input  logic                            issue_valid_i,
    output logic                            issue_ready_o,
    input  logic [2:0][4:0]                 issue_rs_i,
    input  logic [2:0]                      issue_rs_use_i,
    input  logic [4:0]                      issue_rd_i,
    input  logic                            issue_rd_fp_i,
    input  logic [ID_WIDTH-1:0]             issue_id_i,
    input  logic                            commit_valid_i,
    input  logic [ID_WIDTH-1:0]             commit_id_i,
    input  logic                            commit_kill_i,
    input  logic [NUM_WB-1:0]               wb_valid_i,
    input  logic [NUM_WB-1:0][4:0]          wb_rd_i,
    input  logic [NUM_WB-1:0][ID_WIDTH-1:0] wb_id_i,
    output logic                            dep_o,
    output logic [2:0][NUM_WB-1:0]          fwd_o,
    output logic                            committed_o,
    output logic                            busy_o,
    output logic                            err_o
);

    localparam int unsigned   CW      = cnt_width(MAX_INFLIGHT);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_INFLIGHT);

    logic [CW-1:0] cnt_q [NUM_FPR];
    logic [CW-1:0] cnt_d [NUM_FPR];
    logic [CW-1:0] total_q;
    logic [CW-1:0] total_d;
    logic          busy_q;
    logic          err_q;
    logic          underflow;
    logic          hs_fp;
    logic          raw_dep;
    logic          sat_dep;
    logic          rd_wb_hit;
    logic          any_wb;
    logic          commit_set;
    logic          idsb_hit;
    int            avail;
    int            dec;
    int            dec_sum;

    assign commit_set = commit_valid_i & ~commit_kill_i;

    fpu_ss_id_scoreboard #(
        .ID_WIDTH (ID_WIDTH),
        .NUM_WB   (NUM_WB)
    ) i_id_scoreboard (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .flush_i     (flush_i),
        .set_i       (commit_set),
        .set_id_i    (commit_id_i),
        .clr_valid_i (wb_valid_i),
        .clr_id_i    (wb_id_i),
        .query_id_i  (issue_id_i),
        .query_o     (idsb_hit)
    );

    // A same-cycle commit of the candidate's ID counts as committed.
    assign committed_o = idsb_hit | (commit_set & (commit_id_i == issue_id_i));

    // RAW hazard per operand; a pending write can only be forwarded when it
    // is the last one outstanding for that register, otherwise an older
    // write would be bypassed. Lowest matching port wins.
    always_comb begin
        fwd_o   = '0;
        raw_dep = 1'b0;
        for (int i = 0; i < 3; i++) begin
`ifdef FPU_SS_DEP_FORWARDING_EN
            for (int p = NUM_WB - 1; p >= 0; p--) begin
                if (issue_rs_use_i[i] && wb_valid_i[p] &&
                    (wb_rd_i[p] == issue_rs_i[i]) &&
                    (cnt_q[issue_rs_i[i]] == CW'(1))) begin
                    fwd_o[i]    = '0;
                    fwd_o[i][p] = 1'b1;
                end
            end
`endif
            if (issue_rs_use_i[i] && (cnt_q[issue_rs_i[i]] != '0) && (fwd_o[i] == '0)) begin
                raw_dep = 1'b1;
            end
        end
    end

    // Saturation: a full per-register or total count stalls a new FP write
    // unless a writeback this cycle releases the corresponding slot.
    always_comb begin
        rd_wb_hit = 1'b0;
        any_wb    = |wb_valid_i;
        for (int p = 0; p < NUM_WB; p++) begin
            if (wb_valid_i[p] && (wb_rd_i[p] == issue_rd_i)) begin
                rd_wb_hit = 1'b1;
            end
        end
        sat_dep = issue_rd_fp_i &&
                  (((cnt_q[issue_rd_i] == CNT_MAX) && !rd_wb_hit) ||
                   ((total_q == CNT_MAX) && !any_wb));
    end

    assign dep_o         = raw_dep | sat_dep;
    assign issue_ready_o = ~dep_o & ~flush_i & (committed_o | ~issue_rd_fp_i);

    // Net counter update: the issue increment and all writeback decrements
    // of a cycle are combined per register. Decrements beyond what the
    // register holds are an underflow; the counter floors at zero and only
    // the decrements actually absorbed are removed from the total.
    always_comb begin
        hs_fp     = issue_valid_i & issue_ready_o & issue_rd_fp_i;
        underflow = 1'b0;
        dec_sum   = 0;
        avail     = 0;
        dec       = 0;
        for (int r = 0; r < NUM_FPR; r++) begin
            dec = 0;
            for (int p = 0; p < NUM_WB; p++) begin
                if (wb_valid_i[p] && (wb_rd_i[p] == 5'(r))) begin
                    dec = dec + 1;
                end
            end
            avail = int'(cnt_q[r]) + ((hs_fp && (issue_rd_i == 5'(r))) ? 1 : 0);
            if (dec > avail) begin
                underflow = 1'b1;
                cnt_d[r]  = '0;
                dec_sum   = dec_sum + avail;
            end else begin
                cnt_d[r]  = CW'(avail - dec);
                dec_sum   = dec_sum + dec;
            end
        end
        total_d = CW'(int'(total_q) + (hs_fp ? 1 : 0) - dec_sum);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int r = 0; r < NUM_FPR; r++) begin
                cnt_q[r] <= '0;
            end
            total_q <= '0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else if (flush_i) begin
            for (int r = 0; r < NUM_FPR; r++) begin
                cnt_q[r] <= '0;
            end
            total_q <= '0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            total_q <= total_d;
            busy_q  <= (total_d != '0);
            err_q   <= err_q | underflow;
        end
    end

    assign busy_o = busy_q;
    assign err_o  = err_q;

endmodule

// File: tb/tb_fpu_ss_dep_tracker.sv
// Self-checking bench for fpu_ss_dep_tracker: directed scenarios followed by
// randomized traffic, compared every cycle against a behavioural model that
// keeps pending writes per register, a set of committed IDs and an error flag.
module tb_fpu_ss_dep_tracker;
    import fpu_ss_pkg::*;

    localparam int NUM_FPR      = 32;
    localparam int NUM_WB       = 2;
    localparam int ID_WIDTH     = 4;
    localparam int MAX_INFLIGHT = 4;
`ifdef FPU_SS_DEP_FORWARDING_EN
    localparam bit FWD_ON = 1'b1;
`else
    localparam bit FWD_ON = 1'b0;
`endif

    logic                            clk_i = 1'b0;
    logic                            rst_ni;
    logic                            flush_i;
    logic                            issue_valid_i;
    logic                            issue_ready_o;
    logic [2:0][4:0]                 issue_rs_i;
    logic [2:0]                      issue_rs_use_i;
    logic [4:0]                      issue_rd_i;
    logic                            issue_rd_fp_i;
    logic [ID_WIDTH-1:0]             issue_id_i;
    logic                            commit_valid_i;
    logic [ID_WIDTH-1:0]             commit_id_i;
    logic                            commit_kill_i;
    logic [NUM_WB-1:0]               wb_valid_i;
    logic [NUM_WB-1:0][4:0]          wb_rd_i;
    logic [NUM_WB-1:0][ID_WIDTH-1:0] wb_id_i;
    logic                            dep_o;
    logic [2:0][NUM_WB-1:0]          fwd_o;
    logic                            committed_o;
    logic                            busy_o;
    logic                            err_o;

    int testsRun  = 0;
    int failCount = 0;

    // Behavioural model state
    int pend [NUM_FPR];
    bit doneIds [int];
    bit errM;

    logic            expDep;
    logic            expReady;
    logic            expCommitted;
    logic            expBusy;
    logic [2:0][1:0] expFwd;

    fpu_ss_dep_tracker #(
        .NUM_FPR      (NUM_FPR),
        .NUM_WB       (NUM_WB),
        .ID_WIDTH     (ID_WIDTH),
        .MAX_INFLIGHT (MAX_INFLIGHT)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .flush_i        (flush_i),
        .issue_valid_i  (issue_valid_i),
        .issue_ready_o  (issue_ready_o),
        .issue_rs_i     (issue_rs_i),
        .issue_rs_use_i (issue_rs_use_i),
        .issue_rd_i     (issue_rd_i),
        .issue_rd_fp_i  (issue_rd_fp_i),
        .issue_id_i     (issue_id_i),
        .commit_valid_i (commit_valid_i),
        .commit_id_i    (commit_id_i),
        .commit_kill_i  (commit_kill_i),
        .wb_valid_i     (wb_valid_i),
        .wb_rd_i        (wb_rd_i),
        .wb_id_i        (wb_id_i),
        .dep_o          (dep_o),
        .fwd_o          (fwd_o),
        .committed_o    (committed_o),
        .busy_o         (busy_o),
        .err_o          (err_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic idleInputs();
        flush_i        = 1'b0;
        issue_valid_i  = 1'b0;
        issue_rs_i     = '0;
        issue_rs_use_i = '0;
        issue_rd_i     = '0;
        issue_rd_fp_i  = 1'b0;
        issue_id_i     = '0;
        commit_valid_i = 1'b0;
        commit_id_i    = '0;
        commit_kill_i  = 1'b0;
        wb_valid_i     = '0;
        wb_rd_i        = '0;
        wb_id_i        = '0;
    endtask

    function automatic void modelReset();
        foreach (pend[r]) pend[r] = 0;
        doneIds.delete();
        errM = 1'b0;
    endfunction

    // Expected combinational outputs from the model state and current inputs.
    function automatic void computeExpected();
        int       total;
        bit       rdHit;
        bit       anyWb;
        fwd_sel_t sel;
        total  = 0;
        foreach (pend[r]) total += pend[r];
        expBusy = (total != 0);
        expDep  = 1'b0;
        expFwd  = '0;
        for (int i = 0; i < 3; i++) begin
            sel = '0;
            if (FWD_ON && issue_rs_use_i[i]) begin
                for (int p = 0; p < NUM_WB; p++) begin
                    if (sel == '0 && wb_valid_i[p] && wb_rd_i[p] == issue_rs_i[i] &&
                        pend[issue_rs_i[i]] == 1)
                        sel[p] = 1'b1;
                end
            end
            expFwd[i] = sel;
            if (issue_rs_use_i[i] && pend[issue_rs_i[i]] != 0 && sel == '0) expDep = 1'b1;
        end
        rdHit = 1'b0;
        anyWb = 1'b0;
        for (int p = 0; p < NUM_WB; p++) begin
            if (wb_valid_i[p]) begin
                anyWb = 1'b1;
                if (wb_rd_i[p] == issue_rd_i) rdHit = 1'b1;
            end
        end
        if (issue_rd_fp_i && ((pend[issue_rd_i] == MAX_INFLIGHT && !rdHit) ||
                              (total == MAX_INFLIGHT && !anyWb)))
            expDep = 1'b1;
        expCommitted = doneIds.exists(int'(issue_id_i)) ||
                       (commit_valid_i && !commit_kill_i && commit_id_i == issue_id_i);
        expReady = !expDep && !flush_i && (expCommitted || !issue_rd_fp_i);
    endfunction

    // Advance the model by one clock edge with the inputs of that cycle.
    function automatic void modelStep();
        if (flush_i) begin
            modelReset();
            return;
        end
        if (issue_valid_i && expReady && issue_rd_fp_i) pend[issue_rd_i]++;
        for (int p = 0; p < NUM_WB; p++) begin
            if (wb_valid_i[p]) begin
                if (pend[wb_rd_i[p]] > 0) pend[wb_rd_i[p]]--;
                else errM = 1'b1;
                doneIds.delete(int'(wb_id_i[p]));
            end
        end
        if (commit_valid_i && !commit_kill_i) doneIds[int'(commit_id_i)] = 1'b1;
    endfunction

    // Runs one cycle with the inputs currently driven: check, clock, update model.
    task automatic applyStimulus(input string tag);
        #2;
        computeExpected();
        checkOutput({tag, "/dep"},       32'(dep_o),       32'(expDep));
        checkOutput({tag, "/ready"},     32'(issue_ready_o), 32'(expReady));
        checkOutput({tag, "/fwd"},       32'(fwd_o),       32'(expFwd));
        checkOutput({tag, "/committed"}, 32'(committed_o), 32'(expCommitted));
        checkOutput({tag, "/busy"},      32'(busy_o),      32'(expBusy));
        checkOutput({tag, "/err"},       32'(err_o),       32'(errM));
        @(posedge clk_i);
        modelStep();
        #1;
    endtask

    task automatic issueFp(input logic [4:0] rd, input logic [ID_WIDTH-1:0] id);
        idleInputs();
        issue_valid_i = 1'b1;
        issue_rd_i    = rd;
        issue_rd_fp_i = 1'b1;
        issue_id_i    = id;
    endtask

    initial begin
        int pendList[$];
        rst_ni = 1'b0;
        idleInputs();
        modelReset();
        #2;
        checkOutput("rst/busy",  32'(busy_o),        32'd0);
        checkOutput("rst/err",   32'(err_o),         32'd0);
        checkOutput("rst/dep",   32'(dep_o),         32'd0);
        checkOutput("rst/fwd",   32'(fwd_o),         32'd0);
        checkOutput("rst/ready", 32'(issue_ready_o), 32'd1);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;

        // RAW on f3, then writeback on port 0
        idleInputs(); commit_valid_i = 1'b1; commit_id_i = 4'd1;
        applyStimulus("raw_commit");
        issueFp(5'd3, 4'd1);
        applyStimulus("raw_issue_f3");
        idleInputs(); issue_valid_i = 1'b1; issue_rs_i[0] = 5'd3; issue_rs_use_i = 3'b001;
        applyStimulus("raw_stall");
        wb_valid_i = 2'b01; wb_rd_i[0] = 5'd3; wb_id_i[0] = 4'd1;
        applyStimulus("raw_wb");
        idleInputs();
        applyStimulus("raw_idle");

        // Saturation on f5
        commit_valid_i = 1'b1; commit_id_i = 4'd2;
        applyStimulus("sat_commit");
        for (int k = 0; k < 4; k++) begin
            issueFp(5'd5, 4'd2);
            applyStimulus("sat_fill");
        end
        issueFp(5'd5, 4'd2);
        applyStimulus("sat_stall");
        wb_valid_i = 2'b10; wb_rd_i[1] = 5'd5; wb_id_i[1] = 4'd3;
        applyStimulus("sat_release");
        for (int k = 0; k < 4; k++) begin
            idleInputs(); wb_valid_i = 2'b01; wb_rd_i[0] = 5'd5; wb_id_i[0] = 4'd3;
            applyStimulus("sat_drain");
        end

        // Two pending writes to f7: no forward until the last one
        issueFp(5'd7, 4'd2);
        applyStimulus("two_issue");
        issueFp(5'd7, 4'd2);
        applyStimulus("two_issue");
        idleInputs(); issue_valid_i = 1'b1; issue_rs_i[1] = 5'd7; issue_rs_use_i = 3'b010;
        wb_valid_i = 2'b01; wb_rd_i[0] = 5'd7; wb_id_i[0] = 4'd4;
        applyStimulus("two_wb1");
        applyStimulus("two_wb2");
        wb_valid_i = '0;
        applyStimulus("two_clear");

        // Commit bypass versus kill
        issueFp(5'd8, 4'd9);
        commit_valid_i = 1'b1; commit_id_i = 4'd9; commit_kill_i = 1'b1;
        applyStimulus("commit_kill");
        commit_kill_i = 1'b0;
        applyStimulus("commit_bypass");
        idleInputs(); wb_valid_i = 2'b10; wb_rd_i[1] = 5'd8; wb_id_i[1] = 4'd9;
        applyStimulus("commit_drain");

        // Underflow error, sticky until flush
        idleInputs(); wb_valid_i = 2'b01; wb_rd_i[0] = 5'd1; wb_id_i[0] = 4'd5;
        applyStimulus("err_wb");
        issueFp(5'd2, 4'd2);
        applyStimulus("err_hold");
        idleInputs(); flush_i = 1'b1;
        applyStimulus("err_flush");
        idleInputs();
        applyStimulus("err_after");

        // Asynchronous reset with three writes pending
        commit_valid_i = 1'b1; commit_id_i = 4'd2;
        applyStimulus("ares_commit");
        for (int k = 0; k < 3; k++) begin
            issueFp(5'(10 + k), 4'd2);
            applyStimulus("ares_fill");
        end
        idleInputs(); wb_valid_i = 2'b01; wb_rd_i[0] = 5'd1;
        applyStimulus("ares_err");
        idleInputs(); issue_valid_i = 1'b1; issue_rs_i[0] = 5'd10; issue_rs_use_i = 3'b001;
        issue_rd_i = 5'd10; issue_rd_fp_i = 1'b1;
        #2;
        computeExpected();
        checkOutput("ares_pre/dep",  32'(dep_o),  32'(expDep));
        checkOutput("ares_pre/busy", 32'(busy_o), 32'(expBusy));
        #1;
        rst_ni = 1'b0;
        #1;
        checkOutput("ares/busy", 32'(busy_o), 32'd0);
        checkOutput("ares/err",  32'(err_o),  32'd0);
        checkOutput("ares/dep",  32'(dep_o),  32'd0);
        checkOutput("ares/fwd",  32'(fwd_o),  32'd0);
        modelReset();
        idleInputs();
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            idleInputs();
            issue_valid_i  = 1'($urandom_range(0, 1));
            issue_rs_i[0]  = 5'($urandom_range(0, 7));
            issue_rs_i[1]  = 5'($urandom_range(0, 7));
            issue_rs_i[2]  = 5'($urandom_range(0, 7));
            issue_rs_use_i = 3'($urandom_range(0, 7));
            issue_rd_i     = 5'($urandom_range(0, 7));
            issue_rd_fp_i  = 1'($urandom_range(0, 1));
            issue_id_i     = 4'($urandom_range(0, 15));
            commit_valid_i = 1'($urandom_range(0, 1));
            commit_id_i    = 4'($urandom_range(0, 15));
            commit_kill_i  = ($urandom_range(0, 3) == 0);
            pendList = {};
            foreach (pend[r]) if (pend[r] > 0) pendList.push_back(r);
            for (int p = 0; p < NUM_WB; p++) begin
                wb_id_i[p] = 4'($urandom_range(0, 15));
                if (pendList.size() > 0 && $urandom_range(0, 2) == 0) begin
                    wb_valid_i[p] = 1'b1;
                    wb_rd_i[p]    = 5'(pendList[$urandom_range(0, pendList.size() - 1)]);
                end else if ($urandom_range(0, 49) == 0) begin
                    wb_valid_i[p] = 1'b1;
                    wb_rd_i[p]    = 5'($urandom_range(0, 7));
                end
            end
            flush_i = ($urandom_range(0, 39) == 0);
            applyStimulus("rand");
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
